// File: rtl/block_check_pkg.sv
// Shared token-state encoding, keyword character constants and letter helpers
// for the begin/end nesting checker.
package block_check_pkg;

   typedef enum logic [3:0] {
      TOK_IDLE,
      TOK_B1,
      TOK_B2,
      TOK_B3,
      TOK_B4,
      TOK_B5,
      TOK_E1,
      TOK_E2,
      TOK_E3,
      TOK_SKIP
   } tok_state_e;

   localparam logic [7:0] CH_B     = 8'h62;
   localparam logic [7:0] CH_E     = 8'h65;
   localparam logic [7:0] CH_G     = 8'h67;
   localparam logic [7:0] CH_I     = 8'h69;
   localparam logic [7:0] CH_N     = 8'h6e;
   localparam logic [7:0] CH_D     = 8'h64;
   localparam logic [7:0] CH_SPACE = 8'h20;

   function automatic logic is_letter(input logic [7:0] ch);
      return ((ch >= 8'h41) && (ch <= 8'h5a)) || ((ch >= 8'h61) && (ch <= 8'h7a));
   endfunction

   // Uppercase letters fold onto lowercase only when matching is case-insensitive.
   function automatic logic char_is(input logic [7:0] ch, input logic [7:0] expect_ch,
                                    input logic case_sens);
      logic [7:0] folded;
      folded = (!case_sens && (ch >= 8'h41) && (ch <= 8'h5a)) ? (ch | 8'h20) : ch;
      return folded == expect_ch;
   endfunction

endpackage

// File: rtl/kw_token_fsm.sv
// Character-level recogniser that tracks progress through the words "begin"
// and "end"; it only exports its registered state.
module kw_token_fsm
   import block_check_pkg::*;
#(
   parameter int CASE_SENS = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_char,
   input  logic       in_valid,
   output tok_state_e state
);

   localparam logic CS = (CASE_SENS != 0);

   tok_state_e state_q;
   tok_state_e state_d;

   always_comb begin
      state_d = state_q;
      if (in_valid) begin
         if (!is_letter(in_char)) begin
            state_d = TOK_IDLE;
         end else begin
            unique case (state_q)
               TOK_IDLE: begin
                  if (char_is(in_char, CH_B, CS))      state_d = TOK_B1;
                  else if (char_is(in_char, CH_E, CS)) state_d = TOK_E1;
                  else                                 state_d = TOK_SKIP;
               end
               TOK_B1:  state_d = char_is(in_char, CH_E, CS) ? TOK_B2 : TOK_SKIP;
               TOK_B2:  state_d = char_is(in_char, CH_G, CS) ? TOK_B3 : TOK_SKIP;
               TOK_B3:  state_d = char_is(in_char, CH_I, CS) ? TOK_B4 : TOK_SKIP;
               TOK_B4:  state_d = char_is(in_char, CH_N, CS) ? TOK_B5 : TOK_SKIP;
               TOK_E1:  state_d = char_is(in_char, CH_N, CS) ? TOK_E2 : TOK_SKIP;
               TOK_E2:  state_d = char_is(in_char, CH_D, CS) ? TOK_E3 : TOK_SKIP;
               default: state_d = TOK_SKIP;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= TOK_IDLE;
      else       state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/block_nest_checker.sv
// Tracks begin/end nesting over an ASCII stream; a keyword commits when the
// delimiter after it is consumed, while result already reflects the pending word.
module block_nest_checker
   import block_check_pkg::*;
#(
   parameter int DEPTH_W   = 4,
   parameter int CASE_SENS = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         in,
   input  logic               in_valid,
   output logic               result,
   output logic [DEPTH_W-1:0] depth,
   output logic               underflow_err,
   output logic               overflow_err
);

   localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;

   tok_state_e tok_state;

   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               underflow_q, underflow_d;
   logic               overflow_q, overflow_d;
   logic               delim;
   logic signed [DEPTH_W:0] adjust;
   logic signed [DEPTH_W:0] eff;

   kw_token_fsm #(
      .CASE_SENS(CASE_SENS)
   ) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .in_char (in),
      .in_valid(in_valid),
      .state   (tok_state)
   );

   assign delim = in_valid && !is_letter(in);

   // Depth saturates at both ends; the offending commit raises a sticky flag instead.
   always_comb begin
      depth_d     = depth_q;
      underflow_d = underflow_q;
      overflow_d  = overflow_q;
      if (delim && (tok_state == TOK_B5)) begin
         if (depth_q == MAX_DEPTH) overflow_d = 1'b1;
         else                      depth_d    = depth_q + DEPTH_W'(1);
      end else if (delim && (tok_state == TOK_E3)) begin
         if (depth_q == '0) underflow_d = 1'b1;
         else               depth_d     = depth_q - DEPTH_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q     <= '0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         depth_q     <= depth_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end

   always_comb begin
      adjust = '0;
      if (tok_state == TOK_B5)      adjust = {{DEPTH_W{1'b0}}, 1'b1};
      else if (tok_state == TOK_E3) adjust = '1;
   end

   assign eff           = $signed({1'b0, depth_q}) + adjust;
   assign result        = (eff == '0) && !underflow_q && !overflow_q;
   assign depth         = depth_q;
   assign underflow_err = underflow_q;
   assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Scoreboard bench: two checker instances (default and DEPTH_W=2/CASE_SENS=1)
// are fed the same stream and compared against a word-level reference model.
module tb_block_nest_checker;

   logic       clk;
   logic       reset;
   logic [7:0] in_ch;
   logic       in_valid;

   logic       res_a, uf_a, of_a;
   logic [3:0] depth_a;
   logic       res_b, uf_b, of_b;
   logic [1:0] depth_b;

   typedef struct {
      bit res;
      int depth;
      bit uf;
      bit of;
   } exp_t;

   exp_t exp_q_a[$];
   exp_t exp_q_b[$];

   int n_checks;
   int n_errors;

   // Reference model state, index 0 = instance A, 1 = instance B
   int    m_depth[2];
   bit    m_uf[2];
   bit    m_of[2];
   string m_word[2];
   bit    m_cs[2];
   int    m_max[2];

   block_nest_checker #(.DEPTH_W(4), .CASE_SENS(0)) dut_a (
      .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
      .result(res_a), .depth(depth_a), .underflow_err(uf_a), .overflow_err(of_a)
   );

   block_nest_checker #(.DEPTH_W(2), .CASE_SENS(1)) dut_b (
      .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
      .result(res_b), .depth(depth_b), .underflow_err(uf_b), .overflow_err(of_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_alpha(input logic [7:0] ch);
      return ((ch >= 8'h41) && (ch <= 8'h5a)) || ((ch >= 8'h61) && (ch <= 8'h7a));
   endfunction

   // +1 for "begin", -1 for "end", 0 for any other word
   function automatic int kw_value(input string w, input bit cs);
      string k;
      k = cs ? w : w.tolower();
      if (k == "begin") return 1;
      if (k == "end")   return -1;
      return 0;
   endfunction

   task automatic model_step(input int i, input logic [7:0] ch, input logic v, input logic rst);
      int k;
      if (rst) begin
         m_depth[i] = 0;
         m_uf[i]    = 0;
         m_of[i]    = 0;
         m_word[i]  = "";
      end else if (v) begin
         if (is_alpha(ch)) begin
            m_word[i] = $sformatf("%s%c", m_word[i], ch);
         end else begin
            k = kw_value(m_word[i], m_cs[i]);
            if (k == 1) begin
               if (m_depth[i] == m_max[i]) m_of[i] = 1;
               else                        m_depth[i]++;
            end else if (k == -1) begin
               if (m_depth[i] == 0) m_uf[i] = 1;
               else                 m_depth[i]--;
            end
            m_word[i] = "";
         end
      end
   endtask

   function automatic exp_t model_expect(input int i);
      exp_t e;
      e.res   = ((m_depth[i] + kw_value(m_word[i], m_cs[i])) == 0) && !m_uf[i] && !m_of[i];
      e.depth = m_depth[i];
      e.uf    = m_uf[i];
      e.of    = m_of[i];
      return e;
   endfunction

   task automatic applyStimulus(input logic [7:0] ch, input logic v, input logic rst);
      in_ch    = ch;
      in_valid = v;
      reset    = rst;
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i, ch, v, rst);
      exp_q_a.push_back(model_expect(0));
      exp_q_b.push_back(model_expect(1));
      #2;
   endtask

   task automatic sendString(input string s);
      for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1, 1'b0);
   endtask

   task automatic checkOutput(input string name, input exp_t e, input logic res,
                              input int dep, input logic uf, input logic of);
      n_checks += 4;
      if (res !== e.res) begin
         n_errors++;
         $display("[TB] FAIL %s result: got %0b expected %0b at %0t", name, res, e.res, $time);
      end
      if (dep != e.depth) begin
         n_errors++;
         $display("[TB] FAIL %s depth: got %0d expected %0d at %0t", name, dep, e.depth, $time);
      end
      if (uf !== e.uf) begin
         n_errors++;
         $display("[TB] FAIL %s underflow_err: got %0b expected %0b at %0t", name, uf, e.uf, $time);
      end
      if (of !== e.of) begin
         n_errors++;
         $display("[TB] FAIL %s overflow_err: got %0b expected %0b at %0t", name, of, e.of, $time);
      end
   endtask

   // Monitor: outputs settle after each consuming edge, so compare mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q_a.size() > 0) begin
         e = exp_q_a.pop_front();
         checkOutput("instA", e, res_a, int'(depth_a), uf_a, of_a);
      end
      if (exp_q_b.size() > 0) begin
         e = exp_q_b.pop_front();
         checkOutput("instB", e, res_b, int'(depth_b), uf_b, of_b);
      end
   end

   initial begin
      string words[8];
      string delims[4];
      int    wait_cycles;

      words  = '{"begin", "end", "BEGIN", "End", "ends", "beg", "xyz", "bEgIn"};
      delims = '{" ", ".", "\n", "1"};
      m_cs   = '{1'b0, 1'b1};
      m_max  = '{15, 3};
      n_checks = 0;
      n_errors = 0;
      in_ch    = 8'h00;
      in_valid = 1'b0;
      reset    = 1'b1;

      $display("[TB] directed nesting sequences");
      applyStimulus(8'h00, 1'b0, 1'b1);
      sendString("BegIn  end ");
      sendString("endbeginend end ");

      applyStimulus(8'h00, 1'b0, 1'b1);
      sendString("end begin end ");

      applyStimulus(8'h00, 1'b0, 1'b1);
      sendString("begin begin begin begin ");

      applyStimulus(8'h00, 1'b0, 1'b1);
      sendString("BEGIN end ");

      applyStimulus(8'h00, 1'b0, 1'b1);
      sendString("beg");
      for (int i = 0; i < 5; i++) applyStimulus(8'h20 + 8'(i * 17), 1'b0, 1'b0);
      sendString("in ");
      applyStimulus(8'h00, 1'b0, 1'b1);
      sendString("begi");
      applyStimulus(8'h6e, 1'b1, 1'b1);
      sendString("n ");
      sendString("BEGIN");

      $display("[TB] randomized word streams");
      for (int w = 0; w < 400; w++) begin
         string s;
         if ($urandom_range(0, 24) == 0) applyStimulus(8'($urandom), 1'($urandom), 1'b1);
         s = {words[$urandom_range(0, 7)], delims[$urandom_range(0, 3)]};
         for (int c = 0; c < s.len(); c++) begin
            if ($urandom_range(0, 5) == 0) applyStimulus(8'($urandom), 1'b0, 1'b0);
            applyStimulus(s[c], 1'b1, 1'b0);
         end
      end

      wait_cycles = 0;
      while (((exp_q_a.size() != 0) || (exp_q_b.size() != 0)) && (wait_cycles < 10)) begin
         @(posedge clk);
         wait_cycles++;
      end
      if ((exp_q_a.size() != 0) || (exp_q_b.size() != 0)) begin
         n_errors++;
         $display("[TB] FAIL drain: %0d/%0d expectations left, 0 required",
                  exp_q_a.size(), exp_q_b.size());
      end
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
